// File: rtl/spmm_pkg.sv
// Shared SpMM PE datapath constants and types.
`ifndef N
`define N 16
`endif

package spmm_pkg;

  localparam int unsigned N   = `N;
  localparam int unsigned W   = 8;
  localparam int unsigned LGN = $clog2(N);

  typedef logic [W-1:0]   data_t;
  typedef logic [LGN-1:0] idx_t;

endpackage

// File: rtl/seg_scan_stage.sv
// One registered Hillis-Steele segmented-scan stage at distance DIST.
// Segment-end flags, destination indices and valid ride along unchanged.
module seg_scan_stage #(
  parameter int unsigned N    = spmm_pkg::N,
  parameter int unsigned DIST = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          valid,
  input  logic [N*spmm_pkg::W-1:0]      v,
  input  logic [N-1:0]                  f,
  input  logic [N-1:0]                  seg_end,
  input  logic [N*spmm_pkg::LGN-1:0]    idx,
  output logic                          valid_s,
  output logic [N*spmm_pkg::W-1:0]      v_s,
  output logic [N-1:0]                  f_s,
  output logic [N-1:0]                  seg_end_s,
  output logic [N*spmm_pkg::LGN-1:0]    idx_s
);

  localparam int unsigned W = spmm_pkg::W;

  logic [N*W-1:0] v_n;
  logic [N-1:0]   f_n;

  // A lane keeps accumulating from DIST lanes back until it has seen its segment start.
  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i >= DIST) begin : g_add
      assign v_n[i*W +: W] = f[i] ? v[i*W +: W] : data_sum(v[i*W +: W], v[(i-DIST)*W +: W]);
      assign f_n[i]        = f[i] | f[i-DIST];
    end else begin : g_pass
      assign v_n[i*W +: W] = v[i*W +: W];
      assign f_n[i]        = f[i];
    end
  end

  function automatic spmm_pkg::data_t data_sum(input spmm_pkg::data_t a, input spmm_pkg::data_t b);
    return a + b;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) valid_s <= 1'b0;
    else       valid_s <= valid;
  end

  always_ff @(posedge clock) begin
    v_s       <= v_n;
    f_s       <= f_n;
    seg_end_s <= seg_end;
    idx_s     <= idx;
  end

endmodule

// File: rtl/seg_red_unit.sv
// Pipelined segmented reduction: LGN scan stages, then a registered scatter
// that sums every segment result into its destination lane.
module seg_red_unit
  import spmm_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [N*W-1:0]     data,
  input  logic [N-1:0]       split,
  input  logic [N*LGN-1:0]   out_idx,
  output logic               out_valid,
  output logic [N*W-1:0]     out_data,
  output logic [31:0]        delay
);

  logic               valid_p [LGN+1];
  logic [N*W-1:0]     v_p     [LGN+1];
  logic [N-1:0]       f_p     [LGN+1];
  logic [N-1:0]       end_p   [LGN+1];
  logic [N*LGN-1:0]   idx_p   [LGN+1];
  logic [N*W-1:0]     sum_c;
  logic               unused_f;

  assign delay = 32'(LGN + 1);

  // Start flags come from the previous lane's split; lane N-1 always closes a segment.
  assign valid_p[0] = in_valid;
  assign v_p[0]     = data;
  assign f_p[0]     = {split[N-2:0], 1'b1};
  assign end_p[0]   = split | {1'b1, {(N-1){1'b0}}};
  assign idx_p[0]   = out_idx;

  for (genvar k = 0; k < LGN; k++) begin : g_stage
    seg_scan_stage #(
      .N    (N),
      .DIST (32'(1) << k)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .valid     (valid_p[k]),
      .v         (v_p[k]),
      .f         (f_p[k]),
      .seg_end   (end_p[k]),
      .idx       (idx_p[k]),
      .valid_s   (valid_p[k+1]),
      .v_s       (v_p[k+1]),
      .f_s       (f_p[k+1]),
      .seg_end_s (end_p[k+1]),
      .idx_s     (idx_p[k+1])
    );
  end

  assign unused_f = ^f_p[LGN];

  // Colliding destinations accumulate rather than overwrite.
  always_comb begin
    sum_c = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (end_p[LGN][i] && (idx_p[LGN][i*LGN +: LGN] == LGN'(j))) begin
          sum_c[j*W +: W] = sum_c[j*W +: W] + v_p[LGN][i*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= valid_p[LGN];
      out_data  <= valid_p[LGN] ? sum_c : '0;
    end
  end

endmodule
